ring_osc_meter: RTL and testbench

- Multi-channel ring-oscillator frequency meter.
- Holds NUM_RINGS ring oscillators of different lengths. Exactly one is enabled for a programmable window of clk cycles; its rising edges are counted in the ring domain.
- After the window the ring is stopped and allowed to settle, then the frozen count is captured safely into the clk domain.
- Successor to the fixed single-ring, NAND-gated oscillator: adds channel select, gated measurement, saturation and a handshake.

---
 rtl/ring_osc_meter_pkg.sv | 23 ++
 rtl/ring_osc_chain.sv | 22 ++
 rtl/ring_osc_meter.sv | 145 ++++++++++++++
 tb/tb_ring_osc_meter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ring_osc_meter_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the ring-oscillator frequency meter.
package ring_osc_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        CAPTURE
    } meter_state_e;

    localparam int CLEAR_CYC = 2;

    function automatic int ring_len(input int k, input int base_inv, input int step_inv);
        return base_inv + k * step_inv;
    endfunction

    function automatic int sel_width(input int num_rings);
        return (num_rings > 1) ? $clog2(num_rings) : 1;
    endfunction

endpackage

// File: rtl/ring_osc_chain.sv
`timescale 1ns/1ps
// One gated ring: a NAND on the enable followed by LEN inverter cells fed back.
// Each inverter is modelled with a 10 ps delay, giving a period of 2*LEN*10 ps.
module ring_osc_chain #(
    parameter int LEN = 50
) (
    input  logic en,
    output logic osc
);

    logic stage [0:LEN];

    // With en low the NAND holds 1 and the even-length chain parks osc high.
    assign stage[0] = ~(en & stage[LEN]);

    for (genvar i = 0; i < LEN; i++) begin : g_inv
        assign #10ps stage[i+1] = ~stage[i];
    end

    assign osc = stage[LEN];

endmodule

// File: rtl/ring_osc_meter.sv
`timescale 1ns/1ps
// Multi-channel ring-oscillator frequency meter with gated window and saturating count.
// Optional: define RING_OSC_MON_EN to route ring-counter bit 3 to osc_mon.
module ring_osc_meter
    import ring_osc_meter_pkg::*;
#(
    parameter int NUM_RINGS  = 4,
    parameter int BASE_INV   = 50,
    parameter int STEP_INV   = 50,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [sel_width(NUM_RINGS)-1:0] sel,
    input  logic [WIN_W-1:0]                window,
    output logic                            busy,
    output logic                            done,
    output logic [CNT_W-1:0]                count,
    output logic                            overflow,
    output logic                            osc_mon
);

    // state   | meaning
    // IDLE    | waiting for start
    // CLEAR   | ring counter held in clear, all rings stopped
    // RUN     | selected ring enabled for the window
    // SETTLE  | ring stopped, waiting for the last edge to land
    // CAPTURE | frozen count loaded, done pulsed

    localparam int SEL_W = sel_width(NUM_RINGS);
    localparam int TMR_W = (WIN_W > $clog2(SETTLE_CYC + 1)) ? WIN_W : $clog2(SETTLE_CYC + 1);
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_RINGS - 1);

    meter_state_e         state;
    logic [TMR_W-1:0]     timer;
    logic [SEL_W-1:0]     sel_q;
    logic [SEL_W-1:0]     sel_clamped;
    logic [WIN_W-1:0]     win_q;
    logic [NUM_RINGS-1:0] ring_en;
    logic [NUM_RINGS-1:0] ring_osc;
    logic                 ring_clr;
    logic                 ring_clk;
    logic [CNT_W:0]       ring_cnt;

    if ((1 << SEL_W) > NUM_RINGS) begin : g_clamp
        assign sel_clamped = (sel > MAX_SEL) ? MAX_SEL : sel;
    end else begin : g_noclamp
        assign sel_clamped = sel;
    end

    for (genvar k = 0; k < NUM_RINGS; k++) begin : g_ring
        ring_osc_chain #(
            .LEN(ring_len(k, BASE_INV, STEP_INV))
        ) u_chain (
            .en (ring_en[k]),
            .osc(ring_osc[k])
        );
    end

    // sel_q only changes in IDLE while every ring is parked high, so the mux cannot glitch.
    assign ring_clk = ring_osc[sel_q];

    always_ff @(posedge ring_clk or posedge ring_clr) begin
        if (ring_clr) begin
            ring_cnt <= '0;
        end else if (!ring_cnt[CNT_W]) begin
            ring_cnt <= ring_cnt + (CNT_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            sel_q    <= '0;
            win_q    <= '0;
            ring_en  <= '0;
            ring_clr <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sel_q    <= sel_clamped;
                        win_q    <= window;
                        busy     <= 1'b1;
                        ring_clr <= 1'b1;
                        timer    <= TMR_W'(CLEAR_CYC - 1);
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (timer == '0) begin
                        ring_clr <= 1'b0;
                        ring_en  <= NUM_RINGS'(1) << sel_q;
                        timer    <= (win_q == '0) ? '0 : TMR_W'(win_q) - TMR_W'(1);
                        state    <= RUN;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                RUN: begin
                    if (timer == '0) begin
                        ring_en <= '0;
                        timer   <= TMR_W'(SETTLE_CYC - 1);
                        state   <= SETTLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        count    <= ring_cnt[CNT_W] ? '1 : ring_cnt[CNT_W-1:0];
                        overflow <= ring_cnt[CNT_W];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= CAPTURE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RING_OSC_MON_EN
    assign osc_mon = ring_cnt[3];
`else
    assign osc_mon = 1'b0;
`endif

endmodule

// File: tb/tb_ring_osc_meter.sv
`timescale 1ns/1ps
// Randomised self-checking bench for ring_osc_meter against an edge-count model.
module tb_ring_osc_meter;

    localparam int SETTLE = 4;

    logic        clk;
    logic        rst_a, start_a, busy_a, done_a, ovf_a, mon_a;
    logic [1:0]  sel_a;
    logic [15:0] win_a, count_a;
    logic        rst_b, start_b, busy_b, done_b, ovf_b, mon_b;
    logic [1:0]  sel_b;
    logic [15:0] win_b;
    logic [7:0]  count_b;

    int n_cmp = 0;
    int n_bad = 0;

    ring_osc_meter dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .sel(sel_a), .window(win_a),
        .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a), .osc_mon(mon_a)
    );

    ring_osc_meter #(.NUM_RINGS(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .sel(sel_b), .window(win_b),
        .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b), .osc_mon(mon_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp,
                             input longint tol = 0);
        n_cmp++;
        if (obs < exp - tol || obs > exp + tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Rising edges of ring (BASE + k*STEP inverters, 20 ps per inverter per period)
    // that fit into the enabled window of max(w,1) 10 ns clock cycles.
    function automatic int exp_edges(input int nr, input int s, input int w);
        int k, len, weff;
        k    = (s > nr - 1) ? nr - 1 : s;
        len  = 50 + 50 * k;
        weff = (w == 0) ? 1 : w;
        return (weff * 10000) / (20 * len);
    endfunction

    task automatic drive_start(input bit b, input bit st, input int s, input int w);
        if (b) begin
            start_b = st; sel_b = 2'(s); win_b = 16'(w);
        end else begin
            start_a = st; sel_a = 2'(s); win_a = 16'(w);
        end
    endtask

    task automatic set_start(input bit b, input bit st);
        if (b) start_b = st;
        else   start_a = st;
    endtask

    task automatic set_rst(input bit b, input bit r);
        if (b) rst_b = r;
        else   rst_a = r;
    endtask

    task automatic do_meas(input bit b, input int s, input int w,
                           input int restart_at, input int rst_at);
        int     n, lat, dones, exp_lat, budget, edges, cw;
        longint cnt_obs, max_cnt;
        bit     ovf_obs, got, d, bz;
        cw      = b ? 8 : 16;
        max_cnt = (longint'(1) << cw) - 1;
        exp_lat = 4 + ((w == 0) ? 1 : w) + SETTLE;
        edges   = exp_edges(b ? 3 : 4, s, w);
        budget  = exp_lat + 20;
        n = 0; dones = 0; got = 0; lat = 0; cnt_obs = 0; ovf_obs = 0;
        @(negedge clk);
        drive_start(b, 1'b1, s, w);
        while (n < budget) begin
            @(posedge clk);
            n++;
            #1;
            d  = b ? done_b : done_a;
            bz = b ? busy_b : busy_a;
            if (n == 1) begin
                check_val("busy_on", longint'(bz), 1);
                set_start(b, 1'b0);
            end
            if (restart_at > 0 && n == restart_at) drive_start(b, 1'b1, s ^ 1, w + 7);
            if (restart_at > 0 && n == restart_at + 1) set_start(b, 1'b0);
            if (rst_at > 0 && n == rst_at) set_rst(b, 1'b1);
            if (rst_at > 0 && n == rst_at + 1) begin
                check_val("rst_busy", longint'(bz), 0);
                check_val("rst_en", b ? longint'(dut_b.ring_en) : longint'(dut_a.ring_en), 0);
                set_rst(b, 1'b0);
            end
            if (d) begin
                dones++;
                if (!got) begin
                    got     = 1;
                    lat     = n + 1;
                    cnt_obs = b ? longint'(count_b) : longint'(count_a);
                    ovf_obs = b ? ovf_b : ovf_a;
                    check_val("busy_off", longint'(bz), 0);
                end
            end
        end
        if (rst_at > 0) begin
            check_val("no_done", dones, 0);
        end else begin
            check_val("latency", lat, exp_lat);
            check_val("n_done", dones, 1);
            if (edges > max_cnt) begin
                check_val("count_sat", cnt_obs, max_cnt);
                check_val("ovf_set", longint'(ovf_obs), 1);
            end else begin
                check_val("count", cnt_obs, edges, 1);
                check_val("ovf_clr", longint'(ovf_obs), 0);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        drive_start(0, 1'b0, 0, 0);
        drive_start(1, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy_a", longint'(busy_a), 0);
        check_val("rst_done_a", longint'(done_a), 0);
        check_val("rst_count_a", longint'(count_a), 0);
        check_val("rst_ovf_a", longint'(ovf_a), 0);
        check_val("rst_mon_a", longint'(mon_a), 0);
        check_val("rst_en_a", longint'(dut_a.ring_en), 0);
        check_val("rst_busy_b", longint'(busy_b), 0);
        check_val("rst_mon_b", longint'(mon_b), 0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // start coinciding with a reset edge must be dropped
        @(negedge clk);
        rst_a = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        check_val("rst_prio", longint'(busy_a), 0);
        @(negedge clk);
        rst_a = 1'b0; start_a = 1'b0;
        @(posedge clk); #1;
        check_val("rst_prio2", longint'(busy_a), 0);

        do_meas(0, 0, 100, 0, 0);
        do_meas(0, 1, 100, 0, 0);
        do_meas(0, 3, 100, 0, 0);
        do_meas(0, 2, 100, 8, 0);
        do_meas(0, 0, 100, 0, 53);
        do_meas(0, 0, 100, 0, 0);
        do_meas(0, 3, 0, 0, 0);

        do_meas(1, 0, 100, 0, 0);
        do_meas(1, 0, 10, 0, 0);
        do_meas(1, 3, 0, 0, 0);
        do_meas(1, 3, 20, 0, 0);

        repeat (6) begin
            do_meas(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 200)), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
